bayesian_stoch_log: RTL and testbench



---
 rtl/bsl_pkg.sv | 32 +++
 rtl/bsl_lfsr8.sv | 28 ++
 rtl/bayesian_stoch_log.sv | 124 ++++++++++++
 tb/tb_bayesian_stoch_log.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/bsl_pkg.sv
// Shared sizes, LFSR constants and address field helpers for the
// memristor Bayesian-machine array model.
package bsl_pkg;
  localparam int NARRAY     = 2;
  localparam int NWORD      = 6;
  localparam int NWORD_USED = 3;
  localparam int M          = 2 ** NARRAY;
  localparam int W          = 2 ** NWORD_USED;
  localparam int TILE       = 2 ** NWORD;
  localparam int AW         = NARRAY + NWORD;

  // Taps 8,6,5,4 of the Fibonacci register, as a mask on bits [7:0].
  localparam logic [7:0] LFSR_TAPS    = 8'hB8;
  localparam logic [7:0] LFSR_DEFAULT = 8'h01;

  function automatic logic [NARRAY-1:0] tile_sel(input logic [AW-1:0] adr);
    return adr[AW-1:NWORD];
  endfunction

  function automatic logic [NWORD-1:0] local_sel(input logic [AW-1:0] adr);
    return adr[NWORD-1:0];
  endfunction

  // Word reads are aligned: the low bits of the in-tile column are dropped.
  function automatic logic [NWORD-1:0] word_base(input logic [AW-1:0] adr);
    return {adr[NWORD-1:NWORD_USED], {NWORD_USED{1'b0}}};
  endfunction

  function automatic logic lfsr_feedback(input logic [7:0] value);
    return ^(value & LFSR_TAPS);
  endfunction
endpackage

// File: rtl/bsl_lfsr8.sv
// 8-bit Fibonacci LFSR supplying the Bernoulli threshold for one column.
module bsl_lfsr8
  import bsl_pkg::*;
(
  input  logic       clk,
  input  logic       reset_n,
  input  logic       load,
  input  logic [7:0] seed,
  input  logic       step,
  output logic [7:0] value
);
  logic [7:0] value_r;

  // Seed load beats stepping; an all-zero seed would lock up, so it is replaced.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      value_r <= LFSR_DEFAULT;
    end else if (load) begin
      value_r <= (seed == 8'h00) ? LFSR_DEFAULT : seed;
    end else if (step) begin
      value_r <= {value_r[6:0], lfsr_feedback(value_r)};
    end else begin
      value_r <= value_r;
    end
  end

  assign value = value_r;
endmodule

// File: rtl/bayesian_stoch_log.sv
// Bayesian-machine array: tiled likelihood memory, per-tile likelihood
// registers, stochastic (AND of Bernoulli bits) and logarithmic (serial sum) modes.
module bayesian_stoch_log
  import bsl_pkg::*;
(
  input  logic          clk,
  input  logic          reset_n,
  input  logic          CBL,
  input  logic          CBLEN,
  input  logic          CSL,
  input  logic          CWL,
  input  logic          inference,
  input  logic          load_seed,
  input  logic          read_1,
  input  logic          read_8,
  input  logic          load_mem,
  input  logic          read_out,
  input  logic [AW-1:0] adr_full_col,
  input  logic [AW-1:0] adr_full_row,
  input  logic          stoch_log,
  input  logic [W-1:0]  seeds,
  output logic [M-1:0]  bit_out
);
  logic [TILE-1:0]   mem_r [M][M][TILE];
  logic [W-1:0]      lik_r [M][M];
  logic [W-1:0]      shift_r [M];
  logic              ro_seen_r;
  logic [M-1:0]      bit_out_r;

  logic [W-1:0]      lfsr_s [M];
  logic [W-1:0]      read_word_s [M];
  logic [W-1:0]      log_word_s [M];
  logic [M-1:0]      stoch_bits_s;
  logic [NARRAY-1:0] row_tile_s, col_tile_s;
  logic [NWORD-1:0]  row_loc_s, col_loc_s, base_s;
  logic              write_s, strobe_s, read_bit_s;
  logic              stoch_run_s, log_first_s, log_shift_s;

  assign row_tile_s  = tile_sel(adr_full_row);
  assign col_tile_s  = tile_sel(adr_full_col);
  assign row_loc_s   = local_sel(adr_full_row);
  assign col_loc_s   = local_sel(adr_full_col);
  assign base_s      = word_base(adr_full_col);

  assign write_s     = load_mem & CBLEN & CWL & CSL;
  assign strobe_s    = CWL & ~CSL & ~load_mem & ~write_s;
  assign stoch_run_s = inference & ~stoch_log & ~load_seed & ~read_out;
  assign log_first_s = read_out & stoch_log & ~ro_seen_r;
  assign log_shift_s = read_out & stoch_log & ro_seen_r;
  assign read_bit_s  = mem_r[row_tile_s][col_tile_s][row_loc_s][col_loc_s];

  for (genvar c = 0; c < M; c++) begin : g_lfsr
    bsl_lfsr8 u_lfsr (
      .clk     (clk),
      .reset_n (reset_n),
      .load    (load_seed),
      .seed    (seeds ^ W'(c)),
      .step    (stoch_run_s),
      .value   (lfsr_s[c])
    );
  end

  // Per-class Bernoulli AND, saturated log sum and addressed word fetch.
  always_comb begin
    logic                  acc;
    logic [W+NARRAY-1:0]   sum;
    for (int r = 0; r < M; r++) begin
      acc = 1'b1;
      sum = '0;
      for (int c = 0; c < M; c++) begin
        acc = acc & (lik_r[r][c] >= lfsr_s[c]);
        sum = sum + {{NARRAY{1'b0}}, lik_r[r][c]};
      end
      stoch_bits_s[r] = acc;
      log_word_s[r]   = (sum[W+NARRAY-1:W] != '0) ? {W{1'b1}} : sum[W-1:0];
      read_word_s[r]  = mem_r[r][col_tile_s][row_loc_s][base_s +: W];
    end
  end

  // Tile memory is never reset so programmed likelihoods survive a reset.
  always_ff @(posedge clk) begin
    if (write_s) begin
      mem_r[row_tile_s][col_tile_s][row_loc_s][col_loc_s] <= CBL;
    end
  end

  // Likelihood registers, log shift registers, readout edge flag and result bits.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      bit_out_r <= '0;
      ro_seen_r <= 1'b0;
      for (int r = 0; r < M; r++) begin
        shift_r[r] <= '0;
        for (int c = 0; c < M; c++) begin
          lik_r[r][c] <= '0;
        end
      end
    end else begin
      if (strobe_s && read_8) begin
        for (int r = 0; r < M; r++) begin
          lik_r[r][col_tile_s] <= read_word_s[r];
        end
      end
      if (stoch_run_s) begin
        bit_out_r <= stoch_bits_s;
      end else if (log_first_s) begin
        for (int r = 0; r < M; r++) begin
          shift_r[r]   <= log_word_s[r];
          bit_out_r[r] <= log_word_s[r][0];
        end
      end else if (log_shift_s) begin
        for (int r = 0; r < M; r++) begin
          shift_r[r]   <= {1'b0, shift_r[r][W-1:1]};
          bit_out_r[r] <= shift_r[r][1];
        end
      end else if (strobe_s && read_1 && !read_8) begin
        bit_out_r[row_tile_s] <= read_bit_s;
      end
      ro_seen_r <= read_out & (ro_seen_r | log_first_s);
    end
  end

  assign bit_out = bit_out_r;
endmodule

// File: tb/tb_bayesian_stoch_log.sv
// Scoreboard bench for bayesian_stoch_log: a behavioural model predicts
// bit_out for every clock edge; a monitor compares on the falling edge.
module tb_bayesian_stoch_log;
  logic       clk = 1'b0;
  logic       reset_n, CBL, CBLEN, CSL, CWL, inference, load_seed;
  logic       read_1, read_8, load_mem, read_out, stoch_log;
  logic [7:0] adr_full_col, adr_full_row, seeds;
  logic [3:0] bit_out;

  always #5 clk = ~clk;

  bayesian_stoch_log dut (
    .clk(clk), .reset_n(reset_n), .CBL(CBL), .CBLEN(CBLEN), .CSL(CSL), .CWL(CWL),
    .inference(inference), .load_seed(load_seed), .read_1(read_1), .read_8(read_8),
    .load_mem(load_mem), .read_out(read_out), .adr_full_col(adr_full_col),
    .adr_full_row(adr_full_row), .stoch_log(stoch_log), .seeds(seeds), .bit_out(bit_out)
  );

  int         n_cmp = 0;
  int         n_bad = 0;
  logic [3:0] exp_q[$];

  // Reference model state
  bit         mem_m [int];
  int         l_m [4][4];
  int         lfsr_m [4];
  int         sh_m [4];
  bit         seen_m;
  logic [3:0] bit_m;
  int         col_row [4];
  int         col_base [4];

  function automatic void check(string name, logic [31:0] act, logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: actual %0h required %0h at %0t", name, act, req, $time);
    end
  endfunction

  always @(negedge clk) begin
    if (exp_q.size() > 0) check("bit_out", {28'd0, bit_out}, {28'd0, exp_q.pop_front()});
  end

  function automatic int key(int tr, int tc, int row, int col);
    return ((tr * 4 + tc) * 64 + row) * 64 + col;
  endfunction

  function automatic int lfsr_step(int v);
    int fb;
    fb = ((v >> 7) ^ (v >> 5) ^ (v >> 4) ^ (v >> 3)) & 1;
    return ((v << 1) & 255) | fb;
  endfunction

  // Apply the edge rules to the model using the inputs present at the edge.
  task automatic model_edge();
    int tr, tc, rl, cl, s, w;
    bit stoch, strobe;
    logic [3:0] nb;
    tr = int'(adr_full_row[7:6]); rl = int'(adr_full_row[5:0]);
    tc = int'(adr_full_col[7:6]); cl = int'(adr_full_col[5:0]);
    if (!reset_n) begin
      bit_m = 4'd0; seen_m = 1'b0;
      for (int r = 0; r < 4; r++) begin
        sh_m[r] = 0; lfsr_m[r] = 1;
        for (int c = 0; c < 4; c++) l_m[r][c] = 0;
      end
    end else begin
      if (load_mem && CBLEN && CWL && CSL) mem_m[key(tr, tc, rl, cl)] = CBL;
      strobe = CWL && !CSL && !load_mem;
      stoch  = inference && !stoch_log && !load_seed && !read_out;
      nb = bit_m;
      if (stoch) begin
        for (int r = 0; r < 4; r++) begin
          nb[r] = 1'b1;
          for (int c = 0; c < 4; c++) if (l_m[r][c] < lfsr_m[c]) nb[r] = 1'b0;
        end
      end else if (read_out && stoch_log && !seen_m) begin
        for (int r = 0; r < 4; r++) begin
          s = l_m[r][0] + l_m[r][1] + l_m[r][2] + l_m[r][3];
          sh_m[r] = (s > 255) ? 255 : s;
          nb[r] = sh_m[r][0];
        end
        seen_m = 1'b1;
      end else if (read_out && stoch_log) begin
        for (int r = 0; r < 4; r++) begin
          sh_m[r] = sh_m[r] / 2;
          nb[r] = sh_m[r][0];
        end
      end else if (strobe && read_1 && !read_8) begin
        nb[tr] = mem_m[key(tr, tc, rl, cl)];
      end
      for (int c = 0; c < 4; c++) begin
        if (load_seed) begin
          w = int'(seeds) ^ c;
          lfsr_m[c] = (w == 0) ? 1 : w;
        end else if (stoch) begin
          lfsr_m[c] = lfsr_step(lfsr_m[c]);
        end
      end
      if (strobe && read_8) begin
        for (int r = 0; r < 4; r++) begin
          w = 0;
          for (int i = 0; i < 8; i++) w = w + (int'(mem_m[key(r, tc, rl, (cl & 56) + i)]) << i);
          l_m[r][tc] = w;
        end
      end
      if (!read_out) seen_m = 1'b0;
      bit_m = nb;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    exp_q.push_back(bit_m);
    @(negedge clk);
  endtask

  task automatic read_access(int c, int row, int base, bit one_bit, int rsel);
    adr_full_row = 8'(rsel * 64 + row);
    adr_full_col = 8'(c * 64 + base + int'($urandom_range(0, 7)));
    read_8 = !one_bit; read_1 = one_bit;
    CWL = 1'b1; CSL = 1'b1; tick();
    CSL = 1'b0; tick();
    CWL = 1'b0; read_8 = 1'b0; read_1 = 1'b0; tick();
  endtask

  // Program word r of column tile c (all four class tiles) then fetch it.
  task automatic load_col(int c, int row, int base, logic [31:0] words);
    col_row[c] = row; col_base[c] = base;
    load_mem = 1'b1; CBLEN = 1'b1; CWL = 1'b1; CSL = 1'b1;
    for (int r = 0; r < 4; r++) begin
      for (int i = 0; i < 8; i++) begin
        adr_full_row = 8'(r * 64 + row);
        adr_full_col = 8'(c * 64 + base + i);
        CBL = words[8 * r + i];
        tick();
      end
    end
    load_mem = 1'b0; CBLEN = 1'b0; CWL = 1'b0; CSL = 1'b0; tick();
    read_access(c, row, base, 1'b0, int'($urandom_range(0, 3)));
  endtask

  task automatic seed(logic [7:0] s);
    seeds = s; load_seed = 1'b1; tick(); load_seed = 1'b0;
  endtask

  task automatic run_stoch(int n);
    inference = 1'b1; stoch_log = 1'b0;
    repeat (n) tick();
    inference = 1'b0;
  endtask

  task automatic log_read_chk(int r, logic [7:0] expv);
    stoch_log = 1'b1; read_out = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      check("log_serial", {31'd0, bit_out[r]}, (i < 8) ? {31'd0, expv[i]} : 32'd0);
    end
    read_out = 1'b0; tick();
  endtask

  initial begin
    int cnt;
    logic [31:0] rw;
    reset_n = 1'b0; CBL = 1'b0; CBLEN = 1'b0; CSL = 1'b0; CWL = 1'b0; inference = 1'b0;
    load_seed = 1'b0; read_1 = 1'b0; read_8 = 1'b0; load_mem = 1'b0; read_out = 1'b0;
    stoch_log = 1'b0; seeds = 8'h00; adr_full_col = 8'h00; adr_full_row = 8'h00;
    repeat (3) tick();
    reset_n = 1'b1; tick();

    // 0xA5 in tile (0,0) row 5, serial readout LSB first
    load_col(0, 5, 0, 32'h000000A5);
    log_read_chk(0, 8'hA5);

    // Saturated likelihoods, then one zero in class 2
    for (int c = 0; c < 4; c++) load_col(c, 10, 8 * c, 32'hFFFFFFFF);
    seed(8'h3C);
    run_stoch(256);
    load_col(1, 11, 16, 32'hFF00FFFF);
    run_stoch(256);

    // 128/255 threshold over one full LFSR period
    load_col(0, 12, 0, 32'hFFFFFF80);
    seed(8'h01);
    cnt = 0; inference = 1'b1; stoch_log = 1'b0;
    for (int i = 0; i < 255; i++) begin
      tick();
      cnt += int'(bit_out[0]);
    end
    inference = 1'b0;
    check("stoch_count", cnt, 128);

    // Zero seed recovers to 0x01
    seed(8'h00);
    run_stoch(64);

    // Reset mid-run, then re-read memory with default LFSRs
    inference = 1'b1; repeat (30) tick();
    reset_n = 1'b0; tick();
    check("reset_bit_out", {28'd0, bit_out}, 32'd0);
    reset_n = 1'b1; inference = 1'b0; tick();
    read_access(0, 12, 0, 1'b0, 3);
    read_access(1, 11, 16, 1'b0, 0);
    read_access(2, 10, 16, 1'b0, 1);
    read_access(3, 10, 24, 1'b0, 2);
    run_stoch(100);

    // Log sums: class 1 = 100, class 3 saturates to 255
    load_col(0, 20, 0, {8'd100, 8'($urandom), 8'd10, 8'($urandom)});
    load_col(1, 20, 8, {8'd100, 8'($urandom), 8'd20, 8'($urandom)});
    load_col(2, 21, 0, {8'd100, 8'($urandom), 8'd30, 8'($urandom)});
    load_col(3, 22, 56, {8'd100, 8'($urandom), 8'd40, 8'($urandom)});
    log_read_chk(1, 8'd100);
    log_read_chk(3, 8'd255);

    // Randomised configurations
    for (int k = 0; k < 6; k++) begin
      for (int c = 0; c < 4; c++) begin
        rw = $urandom;
        load_col(c, int'($urandom_range(0, 63)), 8 * int'($urandom_range(0, 7)), rw);
      end
      seed(8'($urandom));
      run_stoch(int'($urandom_range(20, 60)));
      inference = 1'b1; stoch_log = 1'b1; repeat (3) tick();
      stoch_log = 1'b0; repeat (5) tick();
      inference = 1'b0;
      stoch_log = 1'b1; read_out = 1'b1; repeat (10) tick();
      read_out = 1'b0; stoch_log = 1'b0; tick();
      for (int j = 0; j < 3; j++) begin
        cnt = int'($urandom_range(0, 3));
        read_access(cnt, col_row[cnt], col_base[cnt], 1'b1, int'($urandom_range(0, 3)));
      end
    end

    repeat (2) tick();
    @(negedge clk);
    #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
